// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/handshake controller driving an external storage array
module fifo_ctrl #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH/2 - 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     mem_en,
  output logic [$clog2(DEPTH)-2:0] mem_w_addr,
  output logic [WIDTH-1:0]         mem_w_data,
  output logic [$clog2(DEPTH)-2:0] mem_r_addr,
  input  logic [WIDTH-1:0]         mem_r_data,
  output logic [$clog2(DEPTH)-1:0] count,
  output logic                     almost_full
);

  // Pointers carry one extra wrap bit above the storage address bits.
  localparam int            PW        = $clog2(DEPTH);
  localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          init_done_q, init_done_d;
  logic          empty, full;
  logic          wr_fire, rd_fire;

  // Status flags, handshakes and storage port wiring from the current pointers
  always_comb begin
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                  (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
    // init_done keeps in_ready low for the first cycle out of reset
    in_ready    = init_done_q && !full;
    out_valid   = !empty;
    wr_fire     = in_valid && in_ready;
    rd_fire     = out_valid && out_ready;
    mem_en      = wr_fire;
    mem_w_addr  = wptr_q[PW-2:0];
    mem_w_data  = in_data;
    mem_r_addr  = rptr_q[PW-2:0];
    // Storage reads are combinational, so the head word is presented directly
    out_data    = mem_r_data;
    count       = wptr_q - rptr_q;
    almost_full = (count >= AF_THRESH);
  end

  // Next-state: each pointer advances independently on its own fire
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    init_done_d = 1'b1;
    if (wr_fire) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_fire) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  // State registers; reset drops all stored words but leaves the array untouched
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      init_done_q <= init_done_d;
    end
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter: DEPTH, default 8; pointer range, power of two, >= 4; storage = DEPTH/2 entries.
REQ-002 Parameter: WIDTH, default 8; data width in bits.
REQ-003 Parameter: AF_LEVEL, default DEPTH/2-1; almost_full threshold, 1..DEPTH/2.
REQ-004 One clock; reset is asynchronous and active-low; ports named clock and resetn.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  producer has a word on in_data.
REQ-008 in_ready  output  1  controller accepts a word this cycle.
REQ-009 in_data  input  WIDTH  producer word.
REQ-010 out_valid  output  1  out_data holds the oldest stored word.
REQ-011 out_ready  input  1  consumer takes the word this cycle.
REQ-012 out_data  output  WIDTH  oldest stored word.
REQ-013 mem_en  output  1  write enable to storage array.
REQ-014 mem_w_addr  output  $clog2(DEPTH)-1  storage write address.
REQ-015 mem_w_data  output  WIDTH  storage write data.
REQ-016 mem_r_addr  output  $clog2(DEPTH)-1  storage read address.
REQ-017 mem_r_data  input  WIDTH  storage read data, combinational from mem_r_addr.
REQ-018 count  output  $clog2(DEPTH)  number of stored words, 0..DEPTH/2.
REQ-019 almost_full  output  1  count >= AF_LEVEL.

Function
REQ-020 Write and read pointers: $clog2(DEPTH) bits each; LSBs address storage, MSB is the wrap bit.
REQ-021 Empty: pointers equal; full: MSBs differ and LSBs equal.
REQ-022 init_done register: 0 in reset, set on the first clock edge after resetn deasserts, then stays 1.
REQ-023 in_ready = init_done AND NOT full (combinational).
REQ-024 Write fire = in_valid AND in_ready; at fire: mem_en=1, mem_w_addr=wptr LSBs, mem_w_data=in_data; wptr increments at the edge.
REQ-025 mem_en=0 whenever write fire is 0; mem_w_data = in_data always.
REQ-026 out_valid = NOT empty; mem_r_addr = rptr LSBs; out_data = mem_r_data (zero read latency).
REQ-027 Read fire = out_valid AND out_ready; rptr increments at the edge.
REQ-028 Write-to-read latency: a word written at edge N is visible on out_data (out_valid=1) after edge N.
REQ-029 Simultaneous write and read fire: both pointers advance; count unchanged.
REQ-030 Full: in_ready=0; a same-cycle read does not enable a write (no pass-through).
REQ-031 Empty: out_valid=0; out_ready ignored; no bypass of in_data to out_data.
REQ-032 Pointers wrap modulo DEPTH; wrap bit toggles every DEPTH/2 increments of the LSBs.
REQ-033 count = (wptr - rptr) mod DEPTH; almost_full derived combinationally from count.
REQ-034 Data order strictly FIFO; no word lost or duplicated under any valid/ready pattern.

Reset
REQ-035 resetn low asynchronously clears wptr, rptr, init_done to 0, independent of clock.
REQ-036 During reset: in_ready=0, out_valid=0, mem_en=0, count=0, almost_full=0 (AF_LEVEL>=1).
REQ-037 Reset mid-operation discards all stored words; storage contents are not cleared.

Verification (DEPTH=8, WIDTH=8, AF_LEVEL=3)
REQ-038 Release reset -> in_ready=0 for first cycle, 1 after first edge; out_valid=0, count=0.
REQ-039 Write 0x11,0x22,0x33,0x44, out_ready=0 -> count=4, in_ready=0, almost_full=1 after third write; fifth word not accepted.
REQ-040 Drain full FIFO with out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, then out_valid=0, count=0.
REQ-041 Continuous write and read for 20 words (values 0..19) -> pointers wrap, count stays 1 steady state, output order 0..19.
REQ-042 Full FIFO, in_valid=1 and out_ready=1 same cycle -> read fires, no write; count 4->3, next cycle in_ready=1.
REQ-043 resetn pulsed low mid-clock with count=2 -> count=0, out_valid=0 immediately; in_ready returns after one edge.
